lab_02: RTL and testbench
=========================

Name: lab_02

Overview:
- Cycle-based text-adventure game controller built from two cooperating Moore FSMs.
- Room FSM, instance name `room`, with state register `room.state`: tracks the player's location from the one-hot-style direction inputs n/s/e/w.
- Sword FSM: remembers whether the sword has been picked up.
- Outputs `win`/`die` flag the two terminal rooms; the block is a standalone top level driven directly by a game bench.

Parameters:
- none

Ports:
- clk    input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset
- n      input  1  move north request
- s      input  1  move south request
- e      input  1  move east request
- w      input  1  move west request
- win    output 1  high while in Victory Vault
- die    output 1  high while in Grievous Graveyard

Behaviour:
- All state updates on the rising edge of clk.
- Reset: reset==0 at a rising edge forces room state to CAVE and clears the sword flag. Reset has priority over all moves.
- Reset mid-game, including from VAULT or GRAVE, returns to CAVE with the sword cleared on that edge.
- Room state register `state`, 3 bits:
  - CAVE=000 (Cave of Cacophony)
  - TUNNEL=001 (Twisty Tunnel)
  - RIVER=010 (Rapid River)
  - STASH=011 (Secret Sword Stash)
  - DEN=100 (Dragon's Den)
  - VAULT=101 (Victory Vault)
  - GRAVE=110 (Grievous Graveyard)
  - Code 111 is illegal and goes to CAVE on the next edge.
- Move priority when several directions are high: n > s > e > w. Only the highest-priority asserted direction is evaluated. If that direction has no exit from the current room, the state holds; lower-priority inputs are not tried.
- Transitions (state holds when no listed input applies):
  - CAVE: e -> TUNNEL.
  - TUNNEL: s -> RIVER; w -> CAVE.
  - RIVER: n -> TUNNEL; e -> DEN; w -> STASH.
  - STASH: e -> RIVER.
  - DEN: next edge unconditionally, inputs ignored. Sword held -> VAULT; otherwise -> GRAVE.
  - VAULT, GRAVE: absorbing; only reset exits.
- Sword FSM: 1-bit flag `sword`.
  - Cleared by reset.
  - Set on the edge after the room state is STASH, i.e. sword_next = sword | (state==STASH).
  - Never cleared except by reset.
- Room FSM receives the sword flag. The DEN decision uses the registered sword value.
  - STASH always leaves to RIVER first, and RIVER -> DEN takes at least one more edge, so a sword picked up is always registered before DEN is evaluated.
- Outputs are Moore and combinational from state only:
  - win = (state==VAULT)
  - die = (state==GRAVE)
  - Both are 0 in every other state, including immediately after reset. win and die are never both 1.
- Latency: a direction applied before edge k changes the outputs after edge k. From DEN, the terminal output appears one edge after entering DEN.

Test Plan:
- Reset, then idle with no inputs for 5 cycles -> win=0, die=0, state=000 throughout.
- Reset, then e, s, e, none -> states TUNNEL, RIVER, DEN, GRAVE. die=1 after the 4th edge and stays 1 for 5 further cycles with random inputs. win=0.
- Reset, then e, s, w, e, e, none -> states TUNNEL, RIVER, STASH, RIVER, DEN, VAULT. win=1 after the 6th edge and holds, die=0.
- Win sequence, then reset=0 for one edge, then e, s, e, none -> CAVE, sword cleared, ends in GRAVE with die=1, win=0.
- Illegal/blocked moves:
  - In CAVE apply n, s, w -> stays CAVE.
  - In TUNNEL apply n=1,s=1 -> n has priority with no exit, so it stays TUNNEL.
  - In TUNNEL apply s=1,w=1 -> RIVER.
- Assert reset while in DEN -> next state CAVE, neither win nor die asserted.

Source files
------------

// File: rtl/lab_02.sv
// Text-adventure controller: a room FSM and a sword FSM.
// win/die decode the terminal rooms straight from the room state.
package lab_02_pkg;
  typedef enum logic [2:0] {
    CAVE   = 3'b000,
    TUNNEL = 3'b001,
    RIVER  = 3'b010,
    STASH  = 3'b011,
    DEN    = 3'b100,
    VAULT  = 3'b101,
    GRAVE  = 3'b110
  } room_t;
endpackage

module lab_02_sword
  import lab_02_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  room_t state,
  output logic  sword
);
  always_ff @(posedge clk) begin
    if (!reset)
      sword <= 1'b0;
    else if (state == STASH)
      sword <= 1'b1;
  end
endmodule

module lab_02_room
  import lab_02_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  n,
  input  logic  s,
  input  logic  e,
  input  logic  w,
  input  logic  sword,
  output room_t state,
  output logic  win,
  output logic  die
);
  logic go_n, go_s, go_e, go_w;

  // only the highest-priority direction counts
  always_comb begin
    go_n = n;
    go_s = s & ~n;
    go_e = e & ~n & ~s;
    go_w = w & ~n & ~s & ~e;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= CAVE;
    end else begin
      case (state)
        CAVE:
          if (go_e) state <= TUNNEL;
        TUNNEL:
          unique case (1'b1)
            go_s:    state <= RIVER;
            go_w:    state <= CAVE;
            default: state <= TUNNEL;
          endcase
        RIVER:
          unique case (1'b1)
            go_n:    state <= TUNNEL;
            go_e:    state <= DEN;
            go_w:    state <= STASH;
            default: state <= RIVER;
          endcase
        STASH:
          if (go_e) state <= RIVER;
        DEN:
          state <= sword ? VAULT : GRAVE;
        VAULT:
          state <= VAULT;
        GRAVE:
          state <= GRAVE;
        default:
          state <= CAVE;
      endcase
    end
  end

  assign win = (state == VAULT);
  assign die = (state == GRAVE);
endmodule

module lab_02
  import lab_02_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic n,
  input  logic s,
  input  logic e,
  input  logic w,
  output logic win,
  output logic die
);
  room_t state;
  logic  sword;

  lab_02_room room (
    .clk   (clk),
    .reset (reset),
    .n     (n),
    .s     (s),
    .e     (e),
    .w     (w),
    .sword (sword),
    .state (state),
    .win   (win),
    .die   (die)
  );

  lab_02_sword sword_fsm (
    .clk   (clk),
    .reset (reset),
    .state (state),
    .sword (sword)
  );
endmodule

// File: tb/tb_lab_02.sv
// Randomized bench for lab_02 against a table-driven room model.
// Directed games pin the model with literal room codes.
module tb_lab_02;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic n = 1'b0, s = 1'b0, e = 1'b0, w = 1'b0;
  logic win, die;

  int checks = 0;
  int errors = 0;

  int m_room = 0;
  bit m_sword = 0;
  int exits [7][4];

  always #5 clk = ~clk;

  lab_02 dut (
    .clk   (clk),
    .reset (reset),
    .n     (n),
    .s     (s),
    .e     (e),
    .w     (w),
    .win   (win),
    .die   (die)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int first_dir(input logic [3:0] d);
    for (int i = 0; i < 4; i++)
      if (d[3-i]) return i;
    return -1;
  endfunction

  task automatic model_step(input logic rn, input logic [3:0] d);
    bit nsw;
    int dir;
    if (!rn) begin
      m_room = 0;
      m_sword = 0;
    end else begin
      nsw = m_sword | (m_room == 3);
      dir = first_dir(d);
      if (m_room == 4)
        m_room = m_sword ? 5 : 6;
      else if (m_room < 4 && dir >= 0 && exits[m_room][dir] >= 0)
        m_room = exits[m_room][dir];
      m_sword = nsw;
    end
  endtask

  // d = {n,s,e,w}; drive after negedge, compare 1ns after posedge
  task automatic step(input logic rn, input logic [3:0] d);
    reset = rn;
    {n, s, e, w} = d;
    @(posedge clk);
    model_step(rn, d);
    #1;
    check("state", int'(dut.room.state), m_room);
    check("win", int'(win), int'(m_room == 5));
    check("die", int'(die), int'(m_room == 6));
    @(negedge clk);
  endtask

  task automatic step_exp(input logic [3:0] d, input int exp_state);
    step(1'b1, d);
    check("pin_state", int'(dut.room.state), exp_state);
  endtask

  localparam logic [3:0] N = 4'b1000, S = 4'b0100;
  localparam logic [3:0] E = 4'b0010, W = 4'b0001, X = 4'b0000;

  initial begin
    for (int r = 0; r < 7; r++)
      for (int d = 0; d < 4; d++)
        exits[r][d] = -1;
    // direction index: 0=n 1=s 2=e 3=w
    exits[0][2] = 1;
    exits[1][1] = 2;
    exits[1][3] = 0;
    exits[2][0] = 1;
    exits[2][2] = 4;
    exits[2][3] = 3;
    exits[3][2] = 2;

    @(negedge clk);
    step(1'b0, X);
    check("reset_win", int'(win), 0);
    check("reset_die", int'(die), 0);
    for (int i = 0; i < 5; i++) step_exp(X, 0);

    step_exp(E, 1);
    step_exp(S, 2);
    step_exp(E, 4);
    step_exp(X, 6);
    check("grave_die", int'(die), 1);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 4'($urandom_range(0, 15)));
      check("grave_hold", int'(die), 1);
    end

    step(1'b0, X);
    step_exp(E, 1);
    step_exp(S, 2);
    step_exp(W, 3);
    step_exp(E, 2);
    step_exp(E, 4);
    step_exp(X, 5);
    check("vault_win", int'(win), 1);
    check("vault_die", int'(die), 0);
    for (int i = 0; i < 3; i++) step_exp(4'($urandom_range(0, 15)), 5);

    step(1'b0, X);
    check("rst_vault", int'(dut.room.state), 0);
    step_exp(E, 1);
    step_exp(S, 2);
    step_exp(E, 4);
    step_exp(X, 6);
    check("reset_sword_die", int'(die), 1);

    step(1'b0, X);
    step_exp(N, 0);
    step_exp(S, 0);
    step_exp(W, 0);
    step_exp(E, 1);
    step_exp(N | S, 1);
    step_exp(S | W, 2);

    step(1'b0, X);
    step_exp(E, 1);
    step_exp(S, 2);
    step_exp(E, 4);
    step(1'b0, X);
    check("den_rst", int'(dut.room.state), 0);
    check("den_rst_win", int'(win), 0);
    check("den_rst_die", int'(die), 0);

    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 39) != 0), 4'($urandom_range(0, 15)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
